btn_sync_debounce: RTL and testbench
====================================

# btn_sync_debounce

Input conditioning stage directly upstream of the 4-bit loadable up-counter. Takes raw, bouncy, asynchronous board inputs (two push-buttons, four slide switches) and produces clean, clock-synchronous controls for the counter: single-cycle `set_pulse`/`clear_pulse` and a debounced `init_out[3:0]` load value. Feeds the counter's `set`, `reset` and `init` inputs one-to-one.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept an input change (20 ms at 50 MHz); legal range 1 .. 2^CNT_W-1.
- `REPEAT_CYCLES`, 25000000: auto-repeat period for a held set button (only with `AUTO_REPEAT_EN`); legal range 1 .. 2^CNT_W-1.
- `CNT_W`, 26: width of every internal cycle counter.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `btn_set`  in  1  raw set button, asynchronous, active-high.
- `btn_clear`  in  1  raw clear button, asynchronous, active-high.
- `sw_init`  in  4  raw slide switches, asynchronous.
- `set_pulse`  out  1  one-cycle pulse per accepted set press.
- `clear_pulse`  out  1  one-cycle pulse per accepted clear press.
- `init_out`  out  4  debounced switch value, registered.

## Operation
- Synchronizers: every raw input passes through a 2-flop synchronizer; all downstream logic uses synchronized values only.
- Per-button FSM (`btn_set`, `btn_clear` each, identical): states REL, PRESS_CHK, HELD, REL_CHK.
  - REL: sync=1 -> PRESS_CHK, counter=1; else stay.
  - PRESS_CHK: sync=0 -> REL, counter=0 (bounce). Sync=1 and counter==DEBOUNCE_CYCLES -> HELD, emit pulse. Else counter+1.
  - HELD: sync=0 -> REL_CHK, counter=1; else stay.
  - REL_CHK: sync=1 -> HELD, counter=0 (no pulse). Sync=0 and counter==DEBOUNCE_CYCLES -> REL. Else counter+1.
- Exactly one pulse per accepted press; releases never pulse.
- Priority: if `clear_pulse` and `set_pulse` would assert on the same edge, only `clear_pulse` asserts; the set press is consumed (no deferred pulse).
- Switch bus: 4-bit synchronized value compared against last sample; any bit change restarts the stability counter at 1. When unchanged for DEBOUNCE_CYCLES cycles and differs from `init_out`, `init_out` loads it. Bus treated as a unit: no partial-bit updates.
- `init_out` updates are independent of buttons; an update and a `set_pulse` on the same edge is legal (counter loads the previous `init_out`).
- Counters saturate at DEBOUNCE_CYCLES; no wrap-around.

## Timing
- Reset (synchronous): synchronizer flops 0, FSMs REL, all counters 0, `set_pulse`=0, `clear_pulse`=0, `init_out`=4'h0, effective on the first edge with `reset`=1.
- Press latency: raw rises before edge k and stays clean -> synchronized 1 at edge k+1 -> pulse high in cycle after edge k+1+DEBOUNCE_CYCLES, for exactly one cycle.
- Switch latency: same, DEBOUNCE_CYCLES+2 edges from clean raw change to `init_out` update.
- Minimum press-to-press spacing: 2*DEBOUNCE_CYCLES+2 cycles.
- Reset mid-operation: all state discarded; a button still held after reset deasserts is a new press and pulses after full debounce latency.
- All outputs registered; no combinational path input -> output.

## Configuration
- `BTN_AUTO_REPEAT_EN` defined: while set FSM is in HELD, an extra `set_pulse` fires every REPEAT_CYCLES cycles (repeat counter starts at 0 on entering HELD, reset on leaving HELD); clear priority still applies to repeats. `clear` never repeats.
- Undefined: no repeat logic, one pulse per press regardless of hold time.

## Test plan
- DEBOUNCE_CYCLES=4: reset, then `btn_set` held 20 cycles -> one `set_pulse` exactly 6 cycles after raw rise, none on release; `init_out`=0 throughout.
- Bounce: `btn_clear` toggles 1,0,1,0 each cycle then held 10 cycles -> single `clear_pulse` 6 cycles after the final rise; no earlier pulse.
- Both buttons rise same cycle, held 10 -> `clear_pulse` once, `set_pulse` never.
- `sw_init` 0 -> 4'hA with 2 glitch cycles to 4'h2 -> `init_out` reaches 4'hA only after 4 stable cycles + 2, never shows 4'h2.
- Reset asserted while `btn_set` in PRESS_CHK, button still held -> no pulse during reset; `set_pulse` 6 cycles after reset release.
- With `BTN_AUTO_REPEAT_EN`, REPEAT_CYCLES=8: `btn_set` held 40 cycles -> pulses at acceptance then every 8 cycles (5 total within hold), none after release.

Source files
------------

// File: rtl/btn_sync_debounce.sv
// Button/switch conditioning for the loadable counter: 2-flop sync, debounce FSMs, debounced switch bus.
// Define BTN_AUTO_REPEAT_EN to make a held set button re-pulse every REPEAT_CYCLES cycles.

module btn_debounce_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000,
    parameter int unsigned CNT_W           = 26,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic fire_c
);
    typedef enum logic [1:0] {REL, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   rep_inc;
    logic               done;
    logic               accept;
    logic               held_stay;
    logic               rep_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REL;
            cnt_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
        end
    end

    // The cycle being sampled counts as one stable cycle, so acceptance happens when cnt_q+1 reaches the target.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        cnt_inc   = cnt_q + CNT_W'(1);
        done      = (cnt_inc >= CNT_W'(DEBOUNCE_CYCLES));
        held_stay = (state_q == HELD) && sync_in;
        rep_inc   = rep_q + CNT_W'(1);
        rep_hit   = (rep_inc == CNT_W'(REPEAT_CYCLES));
        rep_d     = '0;
        case (state_q)
            REL, PRESS_CHK: begin
                if (!sync_in) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    state_d = PRESS_CHK;
                    cnt_d   = cnt_inc;
                end
            end
            HELD, REL_CHK: begin
                if (sync_in) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else begin
                    state_d = REL_CHK;
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
        if (REPEAT_EN && held_stay) begin
            rep_d = rep_hit ? '0 : rep_inc;
        end
        fire_c = accept || (REPEAT_EN && held_stay && rep_hit);
    end
endmodule

module btn_sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_clear,
    input  logic [3:0] sw_init,
    output logic       set_pulse,
    output logic       clear_pulse,
    output logic [3:0] init_out
);
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit SET_REPEAT_EN = 1'b1;
`else
    localparam bit SET_REPEAT_EN = 1'b0;
`endif
    localparam int unsigned IN_W = 6;

    logic [IN_W-1:0]  meta_q, meta_d;
    logic [IN_W-1:0]  sync_q, sync_d;
    logic [3:0]       sw_last_q, sw_last_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [3:0]       init_q, init_d;
    logic             set_pulse_q, set_pulse_d;
    logic             clear_pulse_q, clear_pulse_d;
    logic             set_fire_c;
    logic             clear_fire_c;
    logic [3:0]       sw_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q        <= '0;
            sync_q        <= '0;
            sw_last_q     <= '0;
            sw_cnt_q      <= '0;
            init_q        <= '0;
            set_pulse_q   <= 1'b0;
            clear_pulse_q <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            sw_last_q     <= sw_last_d;
            sw_cnt_q      <= sw_cnt_d;
            init_q        <= init_d;
            set_pulse_q   <= set_pulse_d;
            clear_pulse_q <= clear_pulse_d;
        end
    end

    btn_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W),
        .REPEAT_EN       (SET_REPEAT_EN)
    ) u_set_fsm (
        .clk     (clk),
        .reset   (reset),
        .sync_in (sync_q[0]),
        .fire_c  (set_fire_c)
    );

    btn_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W),
        .REPEAT_EN       (1'b0)
    ) u_clear_fsm (
        .clk     (clk),
        .reset   (reset),
        .sync_in (sync_q[1]),
        .fire_c  (clear_fire_c)
    );

    // Clear wins a same-edge collision; the set press is consumed, not deferred.
    always_comb begin
        meta_d        = {sw_init, btn_clear, btn_set};
        sync_d        = meta_q;
        sw_sync       = sync_q[5:2];
        sw_last_d     = sw_sync;
        sw_cnt_d      = sw_cnt_q;
        init_d        = init_q;
        set_pulse_d   = set_fire_c && !clear_fire_c;
        clear_pulse_d = clear_fire_c;
        if (sw_sync != sw_last_q) begin
            sw_cnt_d = CNT_W'(1);
        end else if (sw_cnt_q < CNT_W'(DEBOUNCE_CYCLES)) begin
            sw_cnt_d = sw_cnt_q + CNT_W'(1);
        end
        if ((sw_cnt_d == CNT_W'(DEBOUNCE_CYCLES)) && (sw_sync != init_q)) begin
            init_d = sw_sync;
        end
    end

    assign set_pulse   = set_pulse_q;
    assign clear_pulse = clear_pulse_q;
    assign init_out    = init_q;
endmodule

// File: tb/tb_btn_sync_debounce.sv
// Self-checking bench for btn_sync_debounce: directed scenarios plus random bouncy inputs against a run-length reference model.
module tb_btn_sync_debounce;
    localparam int unsigned D = 4;
    localparam int unsigned R = 8;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] sw_init = 4'h0;
    logic       set_pulse;
    logic       clear_pulse;
    logic [3:0] init_out;

    int checks = 0;
    int failures = 0;

    btn_sync_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_set     (btn_set),
        .btn_clear   (btn_clear),
        .sw_init     (sw_init),
        .set_pulse   (set_pulse),
        .clear_pulse (clear_pulse),
        .init_out    (init_out)
    );

    always #5 clk = ~clk;

    // Reference model: raw delay line, then per-input run lengths of the synchronized level.
    logic [5:0] m_p1, m_p2;
    int         m_run [2];
    logic       m_prev [2];
    logic       m_lvl [2];
    int         m_rep;
    logic [3:0] m_swprev;
    int         m_swrun;
    logic [3:0] m_init;
    logic       e_set, e_clr;

    // Observation bookkeeping for directed scenarios.
    int idx, set_cnt, clr_cnt, set_at, clr_at, init_a_at;
    logic saw_init2;

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_prev[0] = 1'b0; m_prev[1] = 1'b0;
        m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
        m_rep = 0; m_swprev = '0; m_swrun = 0; m_init = '0;
        e_set = 1'b0; e_clr = 1'b0;
    endtask

    task automatic model_edge(input logic rst, input logic [5:0] raw);
        logic [5:0] syn;
        logic       fire [2];
        logic       was_held;
        logic       s;
        logic [3:0] sw;
        if (rst) begin
            model_reset();
        end else begin
            syn  = m_p2;
            m_p2 = m_p1;
            m_p1 = raw;
            for (int b = 0; b < 2; b++) begin
                s        = syn[b];
                was_held = m_lvl[b] && m_prev[b];
                m_run[b] = (s == m_prev[b]) ? m_run[b] + 1 : 1;
                m_prev[b] = s;
                fire[b]  = 1'b0;
                if (s != m_lvl[b] && m_run[b] >= int'(D)) begin
                    m_lvl[b] = s;
                    fire[b]  = s;
                end
                if (b == 0) begin
                    if (was_held && s) m_rep = m_rep + 1;
                    else               m_rep = 0;
                    if (REP_EN && m_rep > 0 && (m_rep % int'(R)) == 0) fire[0] = 1'b1;
                end
            end
            e_clr = fire[1];
            e_set = fire[0] && !fire[1];
            sw = syn[5:2];
            m_swrun  = (sw == m_swprev) ? m_swrun + 1 : 1;
            m_swprev = sw;
            if (m_swrun >= int'(D) && sw != m_init) m_init = sw;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at idx=%0d", tag, obs, exp, idx);
        end
    endtask

    task automatic clear_obs();
        idx = 0; set_cnt = 0; clr_cnt = 0; set_at = -1; clr_at = -1;
        init_a_at = -1; saw_init2 = 1'b0;
    endtask

    // One clock: drive raw inputs, advance the model on the edge, compare just after it.
    task automatic cyc(input logic rst, input logic bs, input logic bc, input logic [3:0] sw);
        reset = rst; btn_set = bs; btn_clear = bc; sw_init = sw;
        @(posedge clk);
        model_edge(rst, {sw, bc, bs});
        #1;
        chk("set_pulse", 32'(set_pulse), 32'(e_set));
        chk("clear_pulse", 32'(clear_pulse), 32'(e_clr));
        chk("init_out", 32'(init_out), 32'(m_init));
        if (set_pulse === 1'b1) begin
            set_cnt++;
            if (set_at < 0) set_at = idx;
        end
        if (clear_pulse === 1'b1) begin
            clr_cnt++;
            if (clr_at < 0) clr_at = idx;
        end
        if (init_out === 4'h2) saw_init2 = 1'b1;
        if (init_out === 4'hA && init_a_at < 0) init_a_at = idx;
        idx++;
    endtask

    logic       r_set, r_clr, r_rst;
    logic [3:0] r_sw;

    initial begin
        model_reset();
        clear_obs();

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        chk("reset_set", 32'(set_pulse), 32'd0);
        chk("reset_clear", 32'(clear_pulse), 32'd0);
        chk("reset_init", 32'(init_out), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Clean set press held 20 cycles
        clear_obs();
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
        chk("set_latency", 32'(set_at), 32'd5);
        chk("set_count", 32'(set_cnt), REP_EN ? 32'd3 : 32'd1);
        chk("set_init_zero", 32'(init_out), 32'd0);

        // Bouncy clear press
        clear_obs();
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
        chk("bounce_latency", 32'(clr_at), 32'd9);
        chk("bounce_count", 32'(clr_cnt), 32'd1);

        // Simultaneous press: clear wins
        clear_obs();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
        chk("both_clear_count", 32'(clr_cnt), 32'd1);
        chk("both_clear_at", 32'(clr_at), 32'd5);
        chk("both_set_count", 32'(set_cnt), 32'd0);

        // Switch change with a two-cycle glitch
        clear_obs();
        cyc(1'b0, 1'b0, 1'b0, 4'hA);
        cyc(1'b0, 1'b0, 1'b0, 4'h2);
        cyc(1'b0, 1'b0, 1'b0, 4'h2);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 4'hA);
        chk("sw_latency", 32'(init_a_at), 32'd8);
        chk("sw_no_glitch", 32'(saw_init2), 32'd0);
        chk("sw_final", 32'(init_out), 32'hA);

        // Reset while set is being debounced, button kept held
        clear_obs();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        chk("rst_mid_none", 32'(set_cnt), 32'd0);
        chk("rst_mid_init", 32'(init_out), 32'd0);
        clear_obs();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0);
        chk("rst_mid_latency", 32'(set_at), 32'd5);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Long hold: repeats only when enabled
        clear_obs();
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0, 4'h0);
        chk("hold_count", 32'(set_cnt), REP_EN ? 32'd5 : 32'd1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0);
        chk("hold_after_release", 32'(set_cnt), REP_EN ? 32'd5 : 32'd1);

        // Random bouncy traffic against the model
        r_set = 1'b0; r_clr = 1'b0; r_sw = 4'h0; r_rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) r_set = ~r_set;
            if ($urandom_range(7) == 0) r_clr = ~r_clr;
            if ($urandom_range(9) == 0) r_sw = 4'($urandom_range(15));
            r_rst = ($urandom_range(499) == 0);
            cyc(r_rst, r_set, r_clr, r_sw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
